// File: rtl/data_route.sv
// data_route: step engine filling a 64 x 32-bit register RAM, plus a source mux
// feeding an 8-digit multiplexed seven-segment display.
//
// Parameters:
//   STEP_DIV  clocks per step tick in slow mode (frequency=0)
//   SCAN_DIV  clocks per digit-scan tick in slow mode (frequency=0)
// Ports:
//   clk               system clock, rising edge
//   rst               synchronous reset, active-low
//   ram_addr_display  RAM word shown when display=0
//   frequency         1 = tick every clock, 0 = divided ticks
//   display           source select (0 ram, 1 step_cnt, 2 ptr, 3 last_data, 4 addr)
//   AN                digit enables, active-low, digit 0 rightmost
//   SEG               segments, active-low, {dp,g,f,e,d,c,b,a}

`timescale 1ns/1ps

module data_route #(
    parameter int unsigned STEP_DIV = 50_000_000,
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] ram_addr_display,
    input  logic       frequency,
    input  logic [2:0] display,
    output logic [7:0] AN,
    output logic [7:0] SEG
);

    localparam int unsigned StepW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [StepW-1:0] StepLast = StepW'(STEP_DIV - 1);
    localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);

    logic [31:0]      ram_q [64];
    logic [5:0]       ptr_q;
    logic [31:0]      step_cnt_q;
    logic [31:0]      last_data_q;
    logic [StepW-1:0] step_div_q, step_div_d;
    logic [ScanW-1:0] scan_div_q, scan_div_d;
    logic [2:0]       scan_idx_q;

    logic        step_tick;
    logic        scan_tick;
    logic [31:0] src_val;
    logic [3:0]  nibble;
    logic [7:0]  an_d;
    logic [7:0]  seg_d;

    // Tick generation; counters are parked at zero in fast mode so slow mode
    // always resumes with a full period.
    always_comb begin
        step_tick  = frequency | (step_div_q == StepLast);
        scan_tick  = frequency | (scan_div_q == ScanLast);
        step_div_d = (frequency || step_tick) ? '0 : step_div_q + StepW'(1);
        scan_div_d = (frequency || scan_tick) ? '0 : scan_div_q + ScanW'(1);
    end

    // Source select; RAM read is combinational from the register array.
    always_comb begin
        src_val = 32'h0;
        unique case (display)
            3'd0:    src_val = ram_q[ram_addr_display];
            3'd1:    src_val = step_cnt_q;
            3'd2:    src_val = {26'b0, ptr_q};
            3'd3:    src_val = last_data_q;
            3'd4:    src_val = {26'b0, ram_addr_display};
            default: src_val = 32'h0;
        endcase
    end

    always_comb begin
        nibble = src_val[{scan_idx_q, 2'b00} +: 4];
        an_d   = ~(8'b1 << scan_idx_q);
        seg_d  = 8'hFF;
        unique case (nibble)
            4'h0: seg_d = 8'hC0;
            4'h1: seg_d = 8'hF9;
            4'h2: seg_d = 8'hA4;
            4'h3: seg_d = 8'hB0;
            4'h4: seg_d = 8'h99;
            4'h5: seg_d = 8'h92;
            4'h6: seg_d = 8'h82;
            4'h7: seg_d = 8'hF8;
            4'h8: seg_d = 8'h80;
            4'h9: seg_d = 8'h90;
            4'hA: seg_d = 8'h88;
            4'hB: seg_d = 8'h83;
            4'hC: seg_d = 8'hC6;
            4'hD: seg_d = 8'hA1;
            4'hE: seg_d = 8'h86;
            4'hF: seg_d = 8'h8E;
            default: seg_d = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) begin
                ram_q[i] <= 32'h0;
            end
            ptr_q       <= '0;
            step_cnt_q  <= '0;
            last_data_q <= '0;
            step_div_q  <= '0;
            scan_div_q  <= '0;
            scan_idx_q  <= '0;
            AN          <= 8'hFF;
            SEG         <= 8'hFF;
        end else begin
            step_div_q <= step_div_d;
            scan_div_q <= scan_div_d;
            if (step_tick) begin
                ram_q[ptr_q] <= step_cnt_q;
                last_data_q  <= step_cnt_q;
                ptr_q        <= ptr_q + 6'd1;
                step_cnt_q   <= step_cnt_q + 32'd1;
            end
            if (scan_tick) begin
                scan_idx_q <= scan_idx_q + 3'd1;
            end
            // Outputs use pre-edge state, so a same-edge write shows the old word.
            AN  <= an_d;
            SEG <= seg_d;
        end
    end

endmodule

// File: tb/tb_data_route.sv
`timescale 1ns/1ps

module tb_data_route;

    logic       clk = 1'b0;
    logic       rst;
    logic       frequency;
    logic [5:0] addr;
    logic [2:0] display;
    logic [7:0] an;
    logic [7:0] seg;

    always #5 clk = ~clk;

    data_route #(
        .STEP_DIV(4),
        .SCAN_DIV(2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ram_addr_display (addr),
        .frequency        (frequency),
        .display          (display),
        .AN               (an),
        .SEG              (seg)
    );

    int errors = 0;
    int checks = 0;

    // Reference state, advanced once per clock from the documented behaviour.
    logic [31:0] m_ram [64];
    logic [5:0]  m_ptr;
    logic [31:0] m_cnt;
    logic [31:0] m_last;
    int          m_sdiv;
    int          m_cdiv;
    logic [2:0]  m_sidx;
    logic [7:0]  exp_an;
    logic [7:0]  exp_seg;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs from pre-edge state, clock, update model, compare.
    task automatic clock_step(input string tag);
        logic [31:0] v;
        logic        st;
        logic        ct;
        if (!rst) begin
            exp_an  = 8'hFF;
            exp_seg = 8'hFF;
        end else begin
            case (display)
                3'd0:    v = m_ram[addr];
                3'd1:    v = m_cnt;
                3'd2:    v = {26'b0, m_ptr};
                3'd3:    v = m_last;
                3'd4:    v = {26'b0, addr};
                default: v = 32'h0;
            endcase
            exp_an  = ~(8'b1 << m_sidx);
            exp_seg = hex7(v[4*m_sidx +: 4]);
        end
        @(posedge clk);
        #1;
        if (!rst) begin
            for (int i = 0; i < 64; i++) m_ram[i] = 32'h0;
            m_ptr  = 6'd0;
            m_cnt  = 32'd0;
            m_last = 32'd0;
            m_sdiv = 0;
            m_cdiv = 0;
            m_sidx = 3'd0;
        end else begin
            st = frequency || (m_sdiv == 3);
            ct = frequency || (m_cdiv == 1);
            m_sdiv = (frequency || st) ? 0 : m_sdiv + 1;
            m_cdiv = (frequency || ct) ? 0 : m_cdiv + 1;
            if (st) begin
                m_ram[m_ptr] = m_cnt;
                m_last       = m_cnt;
                m_ptr        = m_ptr + 6'd1;
                m_cnt        = m_cnt + 32'd1;
            end
            if (ct) m_sidx = m_sidx + 3'd1;
        end
        check8({tag, " AN"}, an, exp_an);
        check8({tag, " SEG"}, seg, exp_seg);
    endtask

    initial begin
        rst       = 1'b0;
        frequency = 1'b1;
        display   = 3'd0;
        addr      = 6'd0;

        // Reset held: outputs blanked.
        for (int i = 0; i < 10; i++) begin
            clock_step("reset");
            check8("reset hand AN", an, 8'hFF);
            check8("reset hand SEG", seg, 8'hFF);
        end

        // Fast mode, show step count.
        rst     = 1'b1;
        display = 3'd1;
        for (int k = 0; k < 70; k++) begin
            clock_step("fast cnt");
            if (k == 0) begin
                check8("first AN", an, 8'hFE);
                check8("first SEG", seg, 8'hC0);
            end
            if (k == 1) check8("second AN", an, 8'hFD);
            if (k == 7) check8("eighth AN", an, 8'h7F);
            if (k == 8) begin
                check8("wrap AN", an, 8'hFE);
                check8("cnt8 SEG", seg, 8'h80);
            end
        end

        // ram[5] holds 69 = 0x45.
        display = 3'd0;
        addr    = 6'd5;
        for (int k = 0; k < 8; k++) begin
            clock_step("ram5");
            if (an == 8'hFE)      check8("ram5 d0", seg, 8'h92);
            else if (an == 8'hFD) check8("ram5 d1", seg, 8'h99);
            else                  check8("ram5 hi", seg, 8'hC0);
        end

        display = 3'd2;
        for (int k = 0; k < 8; k++) clock_step("ptr");

        display = 3'd5;
        for (int k = 0; k < 8; k++) begin
            clock_step("zero src");
            check8("zero src hand", seg, 8'hC0);
        end

        display = 3'd3;
        for (int k = 0; k < 8; k++) clock_step("last");

        display = 3'd4;
        addr    = 6'd37;
        for (int k = 0; k < 8; k++) clock_step("addr");

        // Display the word being written on this very edge.
        display = 3'd0;
        addr    = m_ptr;
        for (int k = 0; k < 4; k++) clock_step("wr-rd");

        // Slow mode, fast mid-period, back to slow.
        display   = 3'd1;
        frequency = 1'b0;
        for (int k = 0; k < 6; k++) clock_step("slow");
        frequency = 1'b1;
        for (int k = 0; k < 4; k++) clock_step("to fast");
        frequency = 1'b0;
        for (int k = 0; k < 12; k++) clock_step("slow again");

        // Mid-run reset clears RAM.
        rst = 1'b0;
        clock_step("mid reset");
        check8("mid reset hand AN", an, 8'hFF);
        check8("mid reset hand SEG", seg, 8'hFF);
        rst       = 1'b1;
        frequency = 1'b1;
        display   = 3'd0;
        addr      = 6'd40;
        for (int k = 0; k < 41; k++) begin
            clock_step("cleared");
            check8("cleared hand", seg, 8'hC0);
        end
        // ram[40] now 0x28, scan at digit 1.
        clock_step("rewritten");
        check8("rewritten hand AN", an, 8'hFD);
        check8("rewritten hand SEG", seg, 8'hA4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
